// File: rtl/detectfaces_mul_pkg.sv
// Shared sizing helpers, stage-count legality and the signed clip used by the
// pipelined face-detection multiplier.
package detectfaces_mul_pkg;

  // Product width: the extended operands multiply exactly within A_W+B_W+1 bits.
  function automatic int calc_pw(input int a_w, input int b_w);
    return a_w + b_w + 1;
  endfunction

  function automatic longint unsigned round_const(input int shift, input int round);
    if (round != 0 && shift > 0) return 64'd1 << (shift - 1);
    return 64'd0;
  endfunction

  function automatic bit num_stage_ok(input int n);
    return (n >= 1) && (n <= 6);
  endfunction

  function automatic logic signed [127:0] sat_clip(input logic signed [127:0] v, input int ow);
    logic signed [127:0] hi;
    logic signed [127:0] lo;
    hi = (128'sd1 <<< (ow - 1)) - 128'sd1;
    lo = -hi - 128'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/detectfaces_mul_pipe_stage.sv
// One ce-gated pipeline register with a valid bit; data loads only for valid
// slots so the last stage holds its previous result through bubbles and stalls.
module detectfaces_mul_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ce,
  input  logic         i_vld,
  input  logic [W-1:0] i_dat,
  output logic         o_vld,
  output logic [W-1:0] o_dat
);

  logic         r_vld;
  logic [W-1:0] r_dat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld <= 1'b0;
      r_dat <= '0;
    end else if (ce) begin
      r_vld <= i_vld;
      if (i_vld) r_dat <= i_dat;
    end
  end

  assign o_vld = r_vld;
  assign o_dat = r_dat;

endmodule

// File: rtl/detectfaces_mul_pipe.sv
// Pipelined A x B multiplier with round/shift/narrow, NUM_STAGE ce-cycles latency, ce=0 freezes.
// Define DETECTFACES_MUL_SAT_EN to clamp the narrowed result and drive sat_flag.
module detectfaces_mul_pipe
  import detectfaces_mul_pkg::*;
#(
  parameter int A_W       = 16,
  parameter int B_W       = 11,
  parameter int A_SIGNED  = 0,
  parameter int B_SIGNED  = 1,
  parameter int NUM_STAGE = 3,
  parameter int SHIFT     = 0,
  parameter int ROUND     = 0,
  parameter int OUT_W     = 27
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             in_valid,
  input  logic [A_W-1:0]   din0,
  input  logic [B_W-1:0]   din1,
  output logic             out_valid,
  output logic [OUT_W-1:0] dout,
  output logic             sat_flag
);

  localparam int PW = calc_pw(A_W, B_W);
  localparam int RW = PW + 1;
  localparam int M  = (NUM_STAGE >= 2) ? NUM_STAGE - 2 : 0;
  localparam logic signed [RW-1:0] RC = RW'(round_const(SHIFT, ROUND));

  if (!num_stage_ok(NUM_STAGE)) begin : g_bad_num_stage
    $error("detectfaces_mul_pipe: NUM_STAGE=%0d outside 1..6", NUM_STAGE);
  end

  logic [A_W:0]         w_ext_a;
  logic [B_W:0]         w_ext_b;
  logic signed [PW-1:0] w_prd [0:M];
  logic                 w_vm  [0:M];

  assign w_ext_a = (A_SIGNED != 0) ? {din0[A_W-1], din0} : {1'b0, din0};
  assign w_ext_b = (B_SIGNED != 0) ? {din1[B_W-1], din1} : {1'b0, din1};

  // With a single stage the multiply feeds the output register directly.
  if (NUM_STAGE == 1) begin : g_comb_mul
    assign w_prd[0] = PW'($signed(w_ext_a)) * PW'($signed(w_ext_b));
    assign w_vm[0]  = in_valid;
  end else begin : g_opd_stage
    logic [PW:0] w_opd_q;
    detectfaces_mul_pipe_stage #(.W(PW + 1)) u_stg_opd (
      .clk   (clk),
      .reset (reset),
      .ce    (ce),
      .i_vld (in_valid),
      .i_dat ({w_ext_a, w_ext_b}),
      .o_vld (w_vm[0]),
      .o_dat (w_opd_q)
    );
    assign w_prd[0] = PW'($signed(w_opd_q[PW:B_W+1])) * PW'($signed(w_opd_q[B_W:0]));
  end

  for (genvar g = 0; g < M; g++) begin : g_mid
    detectfaces_mul_pipe_stage #(.W(PW)) u_stg_mid (
      .clk   (clk),
      .reset (reset),
      .ce    (ce),
      .i_vld (w_vm[g]),
      .i_dat (w_prd[g]),
      .o_vld (w_vm[g+1]),
      .o_dat (w_prd[g+1])
    );
  end

  // One guard bit above the product keeps the rounding add from overflowing.
  logic signed [RW-1:0] w_sum;
  logic signed [RW-1:0] w_r;
  logic [OUT_W:0]       w_fin_d;
  logic [OUT_W:0]       w_fin_q;

  assign w_sum = RW'(w_prd[M]) + RC;
  assign w_r   = w_sum >>> SHIFT;

`ifdef DETECTFACES_MUL_SAT_EN
  logic signed [127:0] w_r_ext;
  logic signed [127:0] w_clip;
  assign w_r_ext = 128'(w_r);
  assign w_clip  = sat_clip(w_r_ext, OUT_W);
  assign w_fin_d = {w_clip != w_r_ext, OUT_W'(w_clip)};
`else
  assign w_fin_d = {1'b0, OUT_W'(w_r)};
`endif

  detectfaces_mul_pipe_stage #(.W(OUT_W + 1)) u_stg_fin (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .i_vld (w_vm[M]),
    .i_dat (w_fin_d),
    .o_vld (out_valid),
    .o_dat (w_fin_q)
  );

  assign dout     = w_fin_q[OUT_W-1:0];
  assign sat_flag = w_fin_q[OUT_W];

endmodule

// File: tb/tb_detectfaces_mul_pipe.sv
// Scoreboard bench: four multiplier configurations share clk/reset/ce; expectations
// are queued at issue time with the ce-edge count at which each result must appear.
module tb_detectfaces_mul_pipe;

  typedef struct {
    int   dout;
    logic sat;
    int   tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic ce;

  always #5 clk = ~clk;

  // u_dflt: 16u x 11s, 3 stages
  logic        v0, ov0, s0;
  logic [15:0] a0;
  logic [10:0] b0;
  logic [26:0] d0;
  // u_rnd: 8s x 8s, 2 stages, SHIFT=4 ROUND=1, OUT_W=12
  logic        v1, ov1, s1;
  logic [7:0]  a1, b1;
  logic [11:0] d1;
  // u_n1: 8s x 8s, 1 stage, OUT_W=12 (narrowing boundary)
  logic        v2, ov2, s2;
  logic [7:0]  a2, b2;
  logic [11:0] d2;
  // u_n6: 8s x 8s, 6 stages, SHIFT=0 ROUND=1, OUT_W=17
  logic        v3, ov3, s3;
  logic [7:0]  a3, b3;
  logic [16:0] d3;

  detectfaces_mul_pipe #(.A_W(16), .B_W(11), .A_SIGNED(0), .B_SIGNED(1), .NUM_STAGE(3),
                         .SHIFT(0), .ROUND(0), .OUT_W(27)) u_dflt (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(v0), .din0(a0), .din1(b0),
    .out_valid(ov0), .dout(d0), .sat_flag(s0));

  detectfaces_mul_pipe #(.A_W(8), .B_W(8), .A_SIGNED(1), .B_SIGNED(1), .NUM_STAGE(2),
                         .SHIFT(4), .ROUND(1), .OUT_W(12)) u_rnd (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(v1), .din0(a1), .din1(b1),
    .out_valid(ov1), .dout(d1), .sat_flag(s1));

  detectfaces_mul_pipe #(.A_W(8), .B_W(8), .A_SIGNED(1), .B_SIGNED(1), .NUM_STAGE(1),
                         .SHIFT(0), .ROUND(0), .OUT_W(12)) u_n1 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(v2), .din0(a2), .din1(b2),
    .out_valid(ov2), .dout(d2), .sat_flag(s2));

  detectfaces_mul_pipe #(.A_W(8), .B_W(8), .A_SIGNED(1), .B_SIGNED(1), .NUM_STAGE(6),
                         .SHIFT(0), .ROUND(1), .OUT_W(17)) u_n6 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(v3), .din0(a3), .din1(b3),
    .out_valid(ov3), .dout(d3), .sat_flag(s3));

  int   n_vec = 0;
  int   n_bad = 0;
  int   ce_cnt = 0;
  logic ce_last = 1'b0;
  exp_t q0[$], q1[$], q2[$], q3[$];

  always @(posedge clk) begin
    ce_last = ce;
    if (ce && !reset) ce_cnt++;
  end

  function automatic int nst(input int id);
    case (id)
      0: return 3;
      1: return 2;
      2: return 1;
      default: return 6;
    endcase
  endfunction

  function automatic int qn(input int id);
    case (id)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic exp_t qpop(input int id);
    case (id)
      0: return q0.pop_front();
      1: return q1.pop_front();
      2: return q2.pop_front();
      default: return q3.pop_front();
    endcase
  endfunction

  task automatic push(input int id, input int dv, input logic sv);
    exp_t e;
    e.dout = dv;
    e.sat  = sv;
    e.tag  = ce_cnt + nst(id);
    case (id)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  // Integer reference for the random sweeps.
  function automatic exp_t model(input int id, input int a, input int b);
    exp_t   e;
    longint p, r, hi, lo, w;
    int     sh, rd, ow;
    sh = 0; rd = 0; ow = 27;
    case (id)
      1: begin sh = 4; rd = 1; ow = 12; end
      2: ow = 12;
      3: begin rd = 1; ow = 17; end
      default: ;
    endcase
    p = longint'(a) * longint'(b);
    r = p;
    if (rd != 0 && sh > 0) r = r + (longint'(1) <<< (sh - 1));
    r = r >>> sh;
    hi = (longint'(1) <<< (ow - 1)) - 1;
    lo = -hi - 1;
    e.tag = 0;
    e.sat = 1'b0;
`ifdef DETECTFACES_MUL_SAT_EN
    if (r > hi) begin
      e.dout = int'(hi); e.sat = 1'b1;
    end else if (r < lo) begin
      e.dout = int'(lo); e.sat = 1'b1;
    end else begin
      e.dout = int'(r);
    end
`else
    w = r & ((longint'(1) <<< ow) - 1);
    if (w > hi) w = w - (longint'(1) <<< ow);
    e.dout = int'(w);
`endif
    return e;
  endfunction

  task automatic chk(input string nm, input int got, input int want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, want);
    end
  endtask

  task automatic mon(input int id, input logic ov, input int got, input logic sf);
    exp_t e;
    if (ov !== 1'b1) return;
    n_vec++;
    if (qn(id) == 0) begin
      n_bad++;
      $display("FAIL out%0d_unexpected: got dout=%0d sat=%0d, no result pending", id, got, sf);
      return;
    end
    e = qpop(id);
    if (got !== e.dout || sf !== e.sat || ce_cnt != e.tag) begin
      n_bad++;
      $display("FAIL out%0d_result: got dout=%0d sat=%0d at ce-edge %0d, expected dout=%0d sat=%0d at ce-edge %0d",
               id, got, sf, ce_cnt, e.dout, e.sat, e.tag);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && ce_last) begin
      mon(0, ov0, int'($signed(d0)), s0);
      mon(1, ov1, int'($signed(d1)), s1);
      mon(2, ov2, int'($signed(d2)), s2);
      mon(3, ov3, int'($signed(d3)), s3);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
    while ((q0.size() + q1.size() + q2.size() + q3.size()) != 0 && k < 20) begin
      step();
      k++;
    end
    chk({nm, "_pending_after_drain"}, q0.size() + q1.size() + q2.size() + q3.size(), 0);
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  int   ra [6] = '{3, -3, 7, 8, -128, -1};
  int   rb [6] = '{8, 8, 1, 1, -128, 1};
  int   rq [6] = '{2, -1, 0, 1, 1024, 0};
  int   na [4] = '{-128, -128, 10, -7};
  int   nb [4] = '{-128, 127, 10, 9};
`ifdef DETECTFACES_MUL_SAT_EN
  int   nq [4] = '{2047, -2048, 100, -63};
  int   ns [4] = '{1, 1, 0, 0};
`else
  int   nq [4] = '{0, 128, 100, -63};
  int   ns [4] = '{0, 0, 0, 0};
`endif
  int   xa [5] = '{-128, 127, 1, -1, 0};
  int   xb [5] = '{-128, -128, 1, -1, 5};
  int   xq [5] = '{16384, -16256, 1, 1, 0};

  initial begin
    logic sv_ov;
    int   sv_d;
    exp_t e;

    reset = 1'b1; ce = 1'b1;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0; a3 = '0; b3 = '0;
    #2;
    chk("reset_out_valid_dflt", int'(ov0), 0);
    chk("reset_dout_dflt", int'(d0), 0);
    chk("reset_sat_dflt", int'(s0), 0);
    chk("reset_out_valid_n1", int'(ov2), 0);
    chk("reset_out_valid_n6", int'(ov3), 0);
    step(); step();
    reset = 1'b0;
    step();

    // Single extreme pair on the default configuration.
    a0 = 16'd65535; b0 = 11'(-1024); v0 = 1'b1;
    push(0, -67107840, 1'b0);
    step();
    drain("single");
    chk("single_then_out_valid_low", int'(ov0), 0);

    // Streaming with a two-cycle stall and junk inputs while ce=0.
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        ce = 1'b0; v0 = 1'b1; a0 = 16'hBEEF; b0 = 11'h3AB;
        chk("stall_entry_out_valid", int'(ov0), 1);
        chk("stall_entry_dout", int'($signed(d0)), -3);
        sv_ov = ov0; sv_d = int'(d0);
        repeat (2) begin
          step();
          chk("stall_out_valid_frozen", int'(ov0), int'(sv_ov));
          chk("stall_dout_frozen", int'(d0), sv_d);
        end
        ce = 1'b1;
      end
      a0 = 16'(i); b0 = 11'(i - 4); v0 = 1'b1;
      push(0, i * (i - 4), 1'b0);
      step();
    end
    drain("stream");

    // Round-half-up with SHIFT=4.
    for (int k = 0; k < 6; k++) begin
      a1 = 8'(ra[k]); b1 = 8'(rb[k]); v1 = 1'b1;
      push(1, rq[k], 1'b0);
      step();
    end
    drain("round");

    // Narrowing boundary (wrap or clamp) with a single stage.
    for (int k = 0; k < 4; k++) begin
      a2 = 8'(na[k]); b2 = 8'(nb[k]); v2 = 1'b1;
      push(2, nq[k], ns[k][0]);
      step();
    end
    drain("narrow");

    // Exact most-negative product; SHIFT=0 with ROUND=1 adds nothing.
    for (int k = 0; k < 5; k++) begin
      a3 = 8'(xa[k]); b3 = 8'(xb[k]); v3 = 1'b1;
      push(3, xq[k], 1'b0);
      step();
    end
    drain("exact");

    // Asynchronous reset with three pairs in flight.
    a0 = 16'd100; b0 = 11'(-3); v0 = 1'b1; step();
    a0 = 16'd200; b0 = 11'(5);  step();
    a0 = 16'd300; b0 = 11'(7);  step();
    chk("pre_reset_out_valid", int'(ov0), 1);
    chk("pre_reset_dout", int'($signed(d0)), -300);
    v0 = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("async_reset_out_valid", int'(ov0), 0);
    chk("async_reset_dout", int'(d0), 0);
    chk("async_reset_sat", int'(s0), 0);
    step(); step();
    reset = 1'b0;
    repeat (6) begin
      step();
      chk("post_reset_no_stale", int'(ov0), 0);
    end

    // Random sweep on the 1-stage and 6-stage builds with random ce and bubbles.
    for (int n = 0; n < 1000; n++) begin
      ce = ($urandom_range(0, 7) != 0);
      v2 = ($urandom_range(0, 4) != 0); a2 = 8'($urandom); b2 = 8'($urandom);
      v3 = ($urandom_range(0, 4) != 0); a3 = 8'($urandom); b3 = 8'($urandom);
      if (ce && v2) begin
        e = model(2, int'($signed(a2)), int'($signed(b2)));
        push(2, e.dout, e.sat);
      end
      if (ce && v3) begin
        e = model(3, int'($signed(a3)), int'($signed(b3)));
        push(3, e.dout, e.sat);
      end
      step();
    end
    ce = 1'b1;
    drain("sweep");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
